basilisk_sqrt_operation: RTL and testbench
==========================================

Name: basilisk_sqrt_operation

Overview:
- Iterative significand square-root stage of the basilisk FPU.
- Consumes a `basilisk_sqrt_command_t` from the FP decode/dispatch stage.
- Produces an unrounded root (sign, biased exponent, significand, sticky, special flags, round mode) for the shared normalize/round stage.
- Single-entry: one operation in flight, valid/ready on both sides.

Parameters:
- ROOT_BITS, 26, root bits produced: 1 integer + 23 fraction + guard + round. Must be even.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- command_valid  in  1  command offered
- command_ready  out  1  block can accept a command
- command_data  in  $bits(basilisk_sqrt_command_t)  operand a, conditions_a, mode
- result_valid  out  1  result offered
- result_ready  in  1  consumer accepts result
- result_data  out  $bits(basilisk_sqrt_result_t)  sign, exponent[9:0], mantissa[ROOT_BITS-1:0], sticky, nan, inf, zero, invalid, mode

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, result_valid=0, command_ready=1.
  - All result_data fields are 0.
  - Applies mid-operation as well: any in-flight work is discarded.
- FSM states: IDLE, ITERATE, DONE.
  - command_ready is 1 only in IDLE.
  - result_valid is 1 only in DONE.
- IDLE, on accept (command_valid & command_ready): latch mode and sign, then branch:
  - NaN input: nan=1 -> DONE.
  - Negative nonzero, including -inf: invalid=1, nan=1 -> DONE.
  - Zero or denormal (denormals are flushed): zero=1, sign kept -> DONE.
  - +inf: inf=1 -> DONE.
  - Otherwise (normal operand): load the datapath and go to ITERATE.
    - u = exp-127 (signed).
    - Radicand: 2*ROOT_BITS bits with 2 integer bits, holding 1.m.
    - If u is odd, shift the radicand left 1 more and use u-1.
    - result exponent = (u>>>1)+127 (10-bit, biased).
    - rem=0, root=0, counter=0.
- ITERATE, one root bit per cycle, restoring algorithm:
  - rem' = (rem<<2) | next two radicand MSBs; rem is ROOT_BITS+2 bits wide.
  - t = rem' - ((root<<2)|1).
  - If t >= 0: rem=t, root=(root<<1)|1.
  - Else: rem=rem', root=root<<1.
  - The counter increments each cycle. When the counter reaches ROOT_BITS-1, the cycle completes and the FSM goes to DONE with mantissa=root and sticky=(final rem != 0).
- Root is in [1,2), so mantissa[ROOT_BITS-1] is always 1 for normal operands.
- Latency:
  - Normal operand: result_valid rises ROOT_BITS+1 cycles after the accept edge.
  - Special cases: result_valid rises 1 cycle after the accept edge.
- DONE:
  - result_data is held stable while result_valid=1 and result_ready=0.
  - On result_ready, go to IDLE; command_ready rises the next cycle. There is no same-cycle re-accept.
- Unused fields are 0:
  - Special results: mantissa=0, sticky=0, exponent=0.
  - Normal results: nan, inf, zero and invalid are all 0.
- command_valid is ignored outside IDLE.

Optional Feature:
- Macro: BASILISK_SQRT_RADIX4_EN.
- Defined: two restoring steps are chained combinationally per cycle. Normal-operand latency becomes ROOT_BITS/2+1; results are bit-identical.
- Undefined: radix-2 behaviour as above.

Decomposition:
- In package basilisk:
  - `basilisk_sqrt_result_t`, packed: sign, exponent[9:0], mantissa[25:0], sticky, nan, inf, zero, invalid, mode.
  - `basilisk_sqrt_state_t` enum (IDLE/ITERATE/DONE).
  - `BASILISK_SQRT_ROOT_BITS = 26`.
- Reuse `fpu_float_fields_t`, `fpu_float_conditions_t` and `fpu_round_mode_t` unchanged.
- Sub-module: basilisk_sqrt_step, a combinational single restoring step (rem, root, radicand pair in; rem, root out). It is instantiated once, or twice under the macro.

Test Plan:
- a=0x40800000 (4.0) -> exponent=128, mantissa=0x2000000, sticky=0, flags 0; result_valid exactly 27 cycles after accept.
- a=0x40000000 (2.0) -> exponent=127, mantissa[25:2]=0xB504F3, guard=0, round=0, sticky=1.
- a=0xBF800000 (-1.0) -> invalid=1, nan=1, 1-cycle latency. a=0x80000000 (-0.0) -> zero=1, sign=1. a=0x7F800000 (+inf) -> inf=1.
- Backpressure: result_ready held low 5 cycles after result_valid -> result_data stable and command_ready=0 throughout; accept on cycle 6, command_ready=1 the following cycle.
- Reset: rst pulsed low at iteration cycle 10 -> result_valid=0 and command_ready=1 immediately; a next command of 9.0 (0x41100000) -> exponent=128, mantissa=0x3000000, sticky=0.
- Regression under BASILISK_SQRT_RADIX4_EN: same vectors give identical result_data, with 4.0 latency = 14 cycles.

Source files
------------

// File: rtl/basilisk_sqrt_operation_pkg.sv
// -----------------------------------------------------------------------------
// basilisk_sqrt_operation_pkg
//
// Shared types for the basilisk FPU square-root stage:
//   - fpu_float_fields_t / fpu_float_conditions_t / fpu_round_mode_t:
//     the common FPU operand, operand-classification and rounding-mode types
//     produced by the FP decode/dispatch stage.
//   - basilisk_sqrt_command_t: operand a, its classification, rounding mode.
//   - basilisk_sqrt_result_t: unrounded root handed to normalize/round.
//   - basilisk_sqrt_state_t: control FSM states.
//   - basilisk_sqrt_exponent(): biased result exponent of sqrt(a).
// -----------------------------------------------------------------------------
package basilisk_sqrt_operation_pkg;

  // Root bits produced: 1 integer + 23 fraction + guard + round.
  localparam int BASILISK_SQRT_ROOT_BITS = 26;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } fpu_float_fields_t;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic is_denormal;
  } fpu_float_conditions_t;

  typedef enum logic [2:0] {
    FPU_RNE = 3'd0,
    FPU_RTZ = 3'd1,
    FPU_RDN = 3'd2,
    FPU_RUP = 3'd3,
    FPU_RMM = 3'd4
  } fpu_round_mode_t;

  typedef struct packed {
    fpu_float_fields_t     a;
    fpu_float_conditions_t conditions_a;
    fpu_round_mode_t       mode;
  } basilisk_sqrt_command_t;

  typedef struct packed {
    logic                               sign;
    logic [9:0]                         exponent;
    logic [BASILISK_SQRT_ROOT_BITS-1:0] mantissa;
    logic                               sticky;
    logic                               nan;
    logic                               inf;
    logic                               zero;
    logic                               invalid;
    fpu_round_mode_t                    mode;
  } basilisk_sqrt_result_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITERATE = 2'd1,
    DONE    = 2'd2
  } basilisk_sqrt_state_t;

  // Biased exponent of sqrt(a) for a normal operand. The unbiased exponent is
  // forced even (an odd one is absorbed by doubling the radicand), then halved.
  function automatic logic [9:0] basilisk_sqrt_exponent(input logic [7:0] biased_exp);
    logic signed [9:0] unbiased;
    logic signed [9:0] halved;
    unbiased = $signed({2'b00, biased_exp}) - 10'sd127;
    if (unbiased[0]) begin
      unbiased = unbiased - 10'sd1;
    end
    halved = unbiased >>> 1;
    return 10'(halved + 10'sd127);
  endfunction

endpackage

// File: rtl/basilisk_sqrt_step.sv
// -----------------------------------------------------------------------------
// basilisk_sqrt_step
//
// One combinational restoring square-root step: brings down the next two
// radicand bits, trial-subtracts (root<<2)|1 and produces one new root bit.
//
// Ports:
//   rem_in   [ROOT_BITS+1:0]  partial remainder before the step
//   root_in  [ROOT_BITS-1:0]  partial root before the step
//   pair_in  [1:0]            next two radicand bits (MSB first)
//   rem_out  [ROOT_BITS+1:0]  partial remainder after the step
//   root_out [ROOT_BITS-1:0]  partial root after the step (new bit in LSB)
// -----------------------------------------------------------------------------
module basilisk_sqrt_step
  import basilisk_sqrt_operation_pkg::*;
#(
  parameter int ROOT_BITS = BASILISK_SQRT_ROOT_BITS
) (
  input  logic [ROOT_BITS+1:0] rem_in,
  input  logic [ROOT_BITS-1:0] root_in,
  input  logic [1:0]           pair_in,
  output logic [ROOT_BITS+1:0] rem_out,
  output logic [ROOT_BITS-1:0] root_out
);

  logic [ROOT_BITS+1:0] rem_shift;
  logic [ROOT_BITS+1:0] divisor;
  logic [ROOT_BITS+2:0] trial;
  logic                 fits;
  logic                 unused_bits;

  // The remainder never exceeds 2*root and the root has at most ROOT_BITS-1
  // significant bits before the last step, so the top two remainder bits and
  // the root MSB are always zero on entry and can be shifted out.
  assign rem_shift = {rem_in[ROOT_BITS-1:0], pair_in};
  assign divisor   = {root_in, 2'b01};

  // One extra bit so the borrow tells us whether the trial went negative.
  assign trial = {1'b0, rem_shift} - {1'b0, divisor};
  assign fits  = ~trial[ROOT_BITS+2];

  assign rem_out  = fits ? trial[ROOT_BITS+1:0] : rem_shift;
  assign root_out = {root_in[ROOT_BITS-2:0], fits};

  assign unused_bits = ^{rem_in[ROOT_BITS+1:ROOT_BITS], root_in[ROOT_BITS-1]};

endmodule

// File: rtl/basilisk_sqrt_operation.sv
// -----------------------------------------------------------------------------
// basilisk_sqrt_operation
//
// Iterative significand square-root stage of the basilisk FPU. Accepts one
// command at a time, classifies the operand, short-circuits special cases and
// otherwise runs a restoring square root producing ROOT_BITS root bits
// (1 integer + 23 fraction + guard + round) plus a sticky bit. The unrounded
// result goes to the shared normalize/round stage.
//
// Configuration macro:
//   BASILISK_SQRT_RADIX4_EN  - when defined, two restoring steps are chained
//                              per cycle (normal latency ROOT_BITS/2+1 instead
//                              of ROOT_BITS+1); results are bit-identical.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-low reset
//   command_valid  command offered
//   command_ready  block can accept a command (IDLE only)
//   command_data   basilisk_sqrt_command_t: operand a, conditions_a, mode
//   result_valid   result offered (DONE only)
//   result_ready   consumer accepts result
//   result_data    basilisk_sqrt_result_t: sign, exponent, mantissa, sticky,
//                  nan, inf, zero, invalid, mode
// -----------------------------------------------------------------------------
module basilisk_sqrt_operation
  import basilisk_sqrt_operation_pkg::*;
#(
  parameter int ROOT_BITS = BASILISK_SQRT_ROOT_BITS  // must be even
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      command_valid,
  output logic                                      command_ready,
  input  logic [$bits(basilisk_sqrt_command_t)-1:0] command_data,
  output logic                                      result_valid,
  input  logic                                      result_ready,
  output logic [$bits(basilisk_sqrt_result_t)-1:0]  result_data
);

`ifdef BASILISK_SQRT_RADIX4_EN
  localparam int STEPS_PER_CYCLE = 2;
`else
  localparam int STEPS_PER_CYCLE = 1;
`endif

  localparam int ITER_CYCLES = ROOT_BITS / STEPS_PER_CYCLE;
  localparam int COUNT_W     = $clog2(ITER_CYCLES);
  localparam int RAD_W       = 2 * ROOT_BITS;
  localparam int REM_W       = ROOT_BITS + 2;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  basilisk_sqrt_command_t cmd;
  logic                   is_flushed_zero;
  logic [RAD_W-1:0]       radicand_base;
  logic [RAD_W-1:0]       radicand_load;

  assign cmd             = command_data;
  assign is_flushed_zero = cmd.conditions_a.is_zero | cmd.conditions_a.is_denormal;

  // 1.m aligned with two integer bits at the top of the radicand.
  assign radicand_base = {2'b01, cmd.a.mantissa, {(RAD_W-25){1'b0}}};

  // An even biased exponent means an odd unbiased one: double the radicand so
  // the exponent that remains can be halved exactly.
  assign radicand_load = cmd.a.exponent[0] ? radicand_base
                                           : {radicand_base[RAD_W-2:0], 1'b0};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  basilisk_sqrt_state_t  state_reg,    state_next;
  logic [RAD_W-1:0]      radicand_reg, radicand_next;
  logic [REM_W-1:0]      rem_reg,      rem_next;
  logic [ROOT_BITS-1:0]  root_reg,     root_next;
  logic [COUNT_W-1:0]    count_reg,    count_next;
  basilisk_sqrt_result_t result_reg,   result_next;

  // ---------------------------------------------------------------------------
  // Step chain: rem/root flow through STEPS_PER_CYCLE restoring steps, each
  // consuming the next radicand pair from the top of radicand_reg.
  // ---------------------------------------------------------------------------
  logic [REM_W-1:0]     rem_chain  [0:STEPS_PER_CYCLE];
  logic [ROOT_BITS-1:0] root_chain [0:STEPS_PER_CYCLE];

  assign rem_chain[0]  = rem_reg;
  assign root_chain[0] = root_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
      basilisk_sqrt_step #(
        .ROOT_BITS(ROOT_BITS)
      ) u_step (
        .rem_in  (rem_chain[gi]),
        .root_in (root_chain[gi]),
        .pair_in (radicand_reg[RAD_W-1-2*gi -: 2]),
        .rem_out (rem_chain[gi+1]),
        .root_out(root_chain[gi+1])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    radicand_next = radicand_reg;
    rem_next      = rem_reg;
    root_next     = root_reg;
    count_next    = count_reg;
    result_next   = result_reg;

    case (state_reg)
      IDLE: begin
        if (command_valid) begin
          result_next      = '0;
          result_next.sign = cmd.a.sign;
          result_next.mode = cmd.mode;
          state_next       = DONE;

          if (cmd.conditions_a.is_nan) begin
            result_next.nan = 1'b1;
          end else if (cmd.a.sign && !is_flushed_zero) begin
            // Negative nonzero, -inf included.
            result_next.invalid = 1'b1;
            result_next.nan     = 1'b1;
          end else if (is_flushed_zero) begin
            // sqrt(+-0) = +-0; denormals are treated as zero of the same sign.
            result_next.zero = 1'b1;
          end else if (cmd.conditions_a.is_inf) begin
            result_next.inf = 1'b1;
          end else begin
            result_next.exponent = basilisk_sqrt_exponent(cmd.a.exponent);
            radicand_next        = radicand_load;
            rem_next             = '0;
            root_next            = '0;
            count_next           = '0;
            state_next           = ITERATE;
          end
        end
      end

      ITERATE: begin
        rem_next      = rem_chain[STEPS_PER_CYCLE];
        root_next     = root_chain[STEPS_PER_CYCLE];
        radicand_next = {radicand_reg[RAD_W-1-2*STEPS_PER_CYCLE:0],
                         {(2*STEPS_PER_CYCLE){1'b0}}};
        if (count_reg == COUNT_W'(ITER_CYCLES - 1)) begin
          // Last root bits land this cycle; publish straight from the chain.
          result_next.mantissa = root_chain[STEPS_PER_CYCLE];
          result_next.sticky   = |rem_chain[STEPS_PER_CYCLE];
          state_next           = DONE;
        end else begin
          count_next = count_reg + COUNT_W'(1);
        end
      end

      DONE: begin
        // result_reg is untouched here, so data holds through backpressure.
        if (result_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      radicand_reg <= '0;
      rem_reg      <= '0;
      root_reg     <= '0;
      count_reg    <= '0;
      result_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      radicand_reg <= radicand_next;
      rem_reg      <= rem_next;
      root_reg     <= root_next;
      count_reg    <= count_next;
      result_reg   <= result_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign command_ready = (state_reg == IDLE);
  assign result_valid  = (state_reg == DONE);
  assign result_data   = result_reg;

endmodule

// File: tb/tb_basilisk_sqrt_operation.sv
module tb_basilisk_sqrt_operation;
  import basilisk_sqrt_operation_pkg::*;

`ifdef BASILISK_SQRT_RADIX4_EN
  localparam int NORMAL_LAT = 14;
`else
  localparam int NORMAL_LAT = 27;
`endif
  localparam int SPECIAL_LAT = 1;
  localparam int LAT_LIMIT   = 100;

  logic                                      clk;
  logic                                      rst;
  logic                                      command_valid;
  logic                                      command_ready;
  logic [$bits(basilisk_sqrt_command_t)-1:0] command_data;
  logic                                      result_valid;
  logic                                      result_ready;
  logic [$bits(basilisk_sqrt_result_t)-1:0]  result_data;

  int check_count = 0;
  int pass_count  = 0;

  basilisk_sqrt_operation dut (
    .clk          (clk),
    .rst          (rst),
    .command_valid(command_valid),
    .command_ready(command_ready),
    .command_data (command_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand classification as the decode stage would supply it.
  function automatic basilisk_sqrt_command_t make_cmd(input logic [31:0] a,
                                                      input fpu_round_mode_t mode);
    basilisk_sqrt_command_t c;
    c.a                        = a;
    c.conditions_a.is_nan      = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    c.conditions_a.is_inf      = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    c.conditions_a.is_zero     = (a[30:23] == 8'h00) && (a[22:0] == 23'd0);
    c.conditions_a.is_denormal = (a[30:23] == 8'h00) && (a[22:0] != 23'd0);
    c.mode                     = mode;
    return c;
  endfunction

  function automatic basilisk_sqrt_result_t norm_result(input logic [9:0] e,
                                                        input logic [25:0] m,
                                                        input logic s,
                                                        input fpu_round_mode_t mode);
    basilisk_sqrt_result_t r;
    r          = '0;
    r.exponent = e;
    r.mantissa = m;
    r.sticky   = s;
    r.mode     = mode;
    return r;
  endfunction

  // Drive one command; returns #1 after the accept edge.
  task automatic start_op(input logic [31:0] a, input fpu_round_mode_t mode);
    @(negedge clk);
    command_data  = make_cmd(a, mode);
    command_valid = 1'b1;
    @(posedge clk);
    #1;
    command_valid = 1'b0;
  endtask

  // Cycles from the accept edge until result_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 1;
    while (!result_valid && lat < LAT_LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result;
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset;
    #3 rst = 1'b0;
    #10;
    check_count++;
    if (command_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", command_ready);
    else pass_count++;
    check_count++;
    if (result_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", result_valid);
    else pass_count++;
    check_count++;
    if (result_data !== '0) $display("FAIL reset_data: got %h want 0", result_data);
    else pass_count++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_normal;
    logic [31:0]     vec_a    [4] = '{32'h40800000, 32'h40000000, 32'h3E800000, 32'h3F000000};
    logic [9:0]      vec_e    [4] = '{10'd128, 10'd127, 10'd126, 10'd126};
    logic [25:0]     vec_m    [4] = '{26'h2000000, 26'h2D413CC, 26'h2000000, 26'h2D413CC};
    logic            vec_s    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    fpu_round_mode_t vec_mode [4] = '{FPU_RUP, FPU_RNE, FPU_RDN, FPU_RMM};
    basilisk_sqrt_result_t exp_res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      exp_res = norm_result(vec_e[i], vec_m[i], vec_s[i], vec_mode[i]);
      start_op(vec_a[i], vec_mode[i]);
      wait_result(lat);
      $display("normal a=%h lat=%0d result=%h", vec_a[i], lat, result_data);
      check_count++;
      if (lat !== NORMAL_LAT) $display("FAIL normal_lat a=%h: got %0d want %0d", vec_a[i], lat, NORMAL_LAT);
      else pass_count++;
      check_count++;
      if (result_data !== exp_res) $display("FAIL normal_data a=%h: got %h want %h", vec_a[i], result_data, exp_res);
      else pass_count++;
      release_result();
      check_count++;
      if (command_ready !== 1'b1 || result_valid !== 1'b0)
        $display("FAIL normal_release a=%h: got ready=%b valid=%b want ready=1 valid=0",
                 vec_a[i], command_ready, result_valid);
      else pass_count++;
    end
  endtask

  task automatic test_special;
    logic [31:0] vec_a   [6] = '{32'hBF800000, 32'h80000000, 32'h7F800000,
                                 32'h7FC00000, 32'hFF800000, 32'h00000001};
    // {sign, nan, inf, zero, invalid}
    logic [4:0]  vec_flg [6] = '{5'b11001, 5'b10010, 5'b00100,
                                 5'b01000, 5'b11001, 5'b00010};
    basilisk_sqrt_result_t exp_res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      exp_res         = '0;
      exp_res.sign    = vec_flg[i][4];
      exp_res.nan     = vec_flg[i][3];
      exp_res.inf     = vec_flg[i][2];
      exp_res.zero    = vec_flg[i][1];
      exp_res.invalid = vec_flg[i][0];
      exp_res.mode    = FPU_RTZ;
      start_op(vec_a[i], FPU_RTZ);
      wait_result(lat);
      $display("special a=%h lat=%0d result=%h", vec_a[i], lat, result_data);
      check_count++;
      if (lat !== SPECIAL_LAT) $display("FAIL special_lat a=%h: got %0d want %0d", vec_a[i], lat, SPECIAL_LAT);
      else pass_count++;
      check_count++;
      if (result_data !== exp_res) $display("FAIL special_data a=%h: got %h want %h", vec_a[i], result_data, exp_res);
      else pass_count++;
      release_result();
    end
  endtask

  task automatic test_backpressure;
    basilisk_sqrt_result_t exp_res;
    int lat;
    exp_res = norm_result(10'd127, 26'h2D413CC, 1'b1, FPU_RNE);
    start_op(32'h40000000, FPU_RNE);
    wait_result(lat);
    $display("backpressure a=40000000 lat=%0d result=%h", lat, result_data);
    // A competing command offered while stalled must be ignored.
    command_data  = make_cmd(32'hBF800000, FPU_RTZ);
    command_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_count++;
      if (result_valid !== 1'b1 || command_ready !== 1'b0)
        $display("FAIL hold_handshake cycle %0d: got valid=%b ready=%b want valid=1 ready=0",
                 i, result_valid, command_ready);
      else pass_count++;
      check_count++;
      if (result_data !== exp_res) $display("FAIL hold_data cycle %0d: got %h want %h", i, result_data, exp_res);
      else pass_count++;
    end
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready  = 1'b0;
    command_valid = 1'b0;
    check_count++;
    if (command_ready !== 1'b1 || result_valid !== 1'b0)
      $display("FAIL hold_release: got ready=%b valid=%b want ready=1 valid=0", command_ready, result_valid);
    else pass_count++;
  endtask

  task automatic test_reset_mid_op;
    basilisk_sqrt_result_t exp_res;
    int lat;
    start_op(32'h40800000, FPU_RNE);
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    $display("midop reset ready=%b valid=%b result=%h", command_ready, result_valid, result_data);
    check_count++;
    if (result_valid !== 1'b0 || command_ready !== 1'b1)
      $display("FAIL midreset_handshake: got valid=%b ready=%b want valid=0 ready=1", result_valid, command_ready);
    else pass_count++;
    check_count++;
    if (result_data !== '0) $display("FAIL midreset_data: got %h want 0", result_data);
    else pass_count++;
    @(negedge clk);
    rst = 1'b1;
    exp_res = norm_result(10'd128, 26'h3000000, 1'b0, FPU_RNE);
    start_op(32'h41100000, FPU_RNE);
    wait_result(lat);
    $display("after reset a=41100000 lat=%0d result=%h", lat, result_data);
    check_count++;
    if (lat !== NORMAL_LAT) $display("FAIL after_reset_lat: got %0d want %0d", lat, NORMAL_LAT);
    else pass_count++;
    check_count++;
    if (result_data !== exp_res) $display("FAIL after_reset_data: got %h want %h", result_data, exp_res);
    else pass_count++;
    release_result();
  endtask

  initial begin
    rst           = 1'b1;
    command_valid = 1'b0;
    command_data  = '0;
    result_ready  = 1'b0;
    test_reset();
    test_normal();
    test_special();
    test_backpressure();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
